// File: rtl/seg_pkg.sv
// Shared constants, hex font and shadow record for the multiplexed 7-segment driver.
package seg_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned PWM_BITS   = 4;
  localparam int unsigned IDX_MAX_W  = 3;
  localparam int unsigned VAL_W      = 4 * MAX_DIGITS;

  // Active-high {g,f,e,d,c,b,a}; entry 15 first (F, E, d, C, b, A, 9 .. 0)
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [VAL_W-1:0]      value;
    logic [MAX_DIGITS-1:0] dp;
    logic [MAX_DIGITS-1:0] blank;
  } shadow_t;

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational nibble-to-segment lookup (active-high {g..a}).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_c_o
);

  assign seg_c_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed hex 7-segment scanner with PWM brightness, dead time and frame-synchronous loading.
// Optional SEG_LEADING_ZERO_BLANK_EN: automatic blanking of leading zero digits.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned DIV_BITS       = 18,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned        IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]         SEG_POL  = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0]  AN_POL   = {DIGITS{AN_ACTIVE_LOW}};

  logic [DIV_BITS-1:0]  prescaler_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_MAX_W-1:0] idx_w;
  shadow_t              shadow_q, shadow_d, pending_q, pending_d, load_word;
  logic                 pending_valid_q, pending_valid_d;
  logic                 tick, wrap, slot_on;
  logic [PWM_BITS-1:0]  phase;
  logic [3:0]           nibble;
  logic [6:0]           font_seg, seg_act;
  logic                 blank_bit, dp_act;
  logic [DIGITS-1:0]    an_act;
  logic [6:0]           seg_q;
  logic                 dp_q, frame_done_q;
  logic [DIGITS-1:0]    an_q;

  assign tick    = &prescaler_q;
  assign wrap    = tick && (idx_q == '0);
  assign phase   = prescaler_q[DIV_BITS-1 -: PWM_BITS];
  assign slot_on = (phase != '0) && (phase <= brightness);
  assign idx_w   = IDX_MAX_W'(idx_q);

  always_comb begin
    load_word       = '0;
    load_word.value = VAL_W'(value);
    load_word.dp    = MAX_DIGITS'(dp_in);
    load_word.blank = MAX_DIGITS'(blank_in);
  end

  // Scan index and tear-free shadow update: shadow only changes at frame wrap
  always_comb begin
    idx_d           = idx_q;
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    if (tick) begin
      idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
    end
    if (wrap) begin
      if (load) begin
        shadow_d = load_word;
      end else if (pending_valid_q) begin
        shadow_d = pending_q;
      end
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_d       = load_word;
      pending_valid_d = 1'b1;
    end
  end

  assign nibble = shadow_q.value[{idx_w, 2'b00} +: 4];

  seg_hex_decode u_hex_decode (
    .nibble_i (nibble),
    .seg_c_o  (font_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [MAX_DIGITS-1:0] lz_q, lz_d;
  logic                  all_zero;

  // Digits above the highest nonzero nibble; digit 0 always shown
  always_comb begin
    lz_d     = '0;
    all_zero = 1'b1;
    for (int i = int'(MAX_DIGITS) - 1; i >= 1; i--) begin
      if (i < int'(DIGITS)) begin
        all_zero = all_zero && (shadow_d.value[4*i +: 4] == 4'h0);
        lz_d[i]  = all_zero;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lz_q <= '0;
    end else begin
      lz_q <= lz_d;
    end
  end

  assign blank_bit = shadow_q.blank[idx_w] | lz_q[idx_w];
`else
  assign blank_bit = shadow_q.blank[idx_w];
`endif

  assign seg_act = blank_bit ? 7'h00 : font_seg;
  assign dp_act  = shadow_q.dp[idx_w] && !blank_bit;
  assign an_act  = slot_on ? (DIGITS'(1) << idx_q) : '0;

  // State and output registers; polarity applied only here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler_q     <= '0;
      idx_q           <= IDX_LAST;
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      an_q            <= AN_POL;
      seg_q           <= SEG_POL;
      dp_q            <= SEG_ACTIVE_LOW;
      frame_done_q    <= 1'b0;
    end else begin
      prescaler_q     <= prescaler_q + DIV_BITS'(1);
      idx_q           <= idx_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      an_q            <= an_act ^ AN_POL;
      seg_q           <= seg_act ^ SEG_POL;
      dp_q            <= dp_act ^ SEG_ACTIVE_LOW;
      frame_done_q    <= wrap;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed scoreboard bench for seg_scan_driver (DIGITS=4, DIV_BITS=5, active-low pins).
module tb_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int DIV_BITS = 5;

  logic              clock;
  logic              reset;
  logic [15:0]       value;
  logic              load;
  logic [3:0]        dp_in;
  logic [3:0]        blank_in;
  logic [3:0]        brightness;
  logic [6:0]        seg;
  logic              dp;
  logic [3:0]        an;
  logic              frame_done;

  typedef struct {
    int         digit;
    int         on_cnt;
    logic [6:0] seg;
    logic       dp;
    int         fd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  seg_scan_driver #(
    .DIGITS         (DIGITS),
    .DIV_BITS       (DIV_BITS),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Standard hex font, active-high {g..a}
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'b0111111;
      4'h1: font = 7'b0000110;
      4'h2: font = 7'b1011011;
      4'h3: font = 7'b1001111;
      4'h4: font = 7'b1100110;
      4'h5: font = 7'b1101101;
      4'h6: font = 7'b1111101;
      4'h7: font = 7'b0000111;
      4'h8: font = 7'b1111111;
      4'h9: font = 7'b1101111;
      4'hA: font = 7'b1110111;
      4'hB: font = 7'b1111100;
      4'hC: font = 7'b0111001;
      4'hD: font = 7'b1011110;
      4'hE: font = 7'b1111001;
      default: font = 7'b1110001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue the expected appearance of one full frame (digits 3 down to 0)
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] blm,
                            input int on_cnt);
    logic [3:0] lz;
    exp_t       e;
    lz = 4'b0000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      int hi;
      hi = 0;
      for (int d = 0; d < 4; d++) if (v[4*d +: 4] != 4'h0) hi = d;
      for (int d = 1; d < 4; d++) if (d > hi) lz[d] = 1'b1;
    end
`endif
    for (int d = 3; d >= 0; d--) begin
      e.digit  = d;
      e.on_cnt = on_cnt;
      e.fd     = (d == 0) ? 1 : 0;
      if (blm[d] || lz[d]) begin
        e.seg = 7'b1111111;
        e.dp  = 1'b1;
      end else begin
        e.seg = ~font(v[4*d +: 4]);
        e.dp  = ~dpm[d];
      end
      sb.push_back(e);
    end
  endtask

  // Observe one 32-clock digit slot, optionally strobing load at sample load_j
  task automatic run_slot(input int load_j, input logic [15:0] lv, input logic [3:0] ldp,
                          input logic [3:0] lbl);
    exp_t       e;
    logic [3:0] one, exp_an;
    int         on, bad, first, fd;
    logic [6:0] s;
    logic       p;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e      = sb.pop_front();
    one    = 4'b0001;
    exp_an = ~(one << e.digit);
    on = 0; bad = 0; first = -1; fd = 0;
    s = 7'h00; p = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clock);
      if (an === exp_an) begin
        on++;
        if (first < 0) first = j;
      end else if (an !== 4'b1111) begin
        bad++;
      end
      if (frame_done === 1'b1) fd++;
      if (j == 32) begin
        s = seg;
        p = dp;
      end
      if (j == load_j) begin
        load = 1'b1; value = lv; dp_in = ldp; blank_in = lbl;
      end else begin
        load = 1'b0;
      end
    end
    check($sformatf("an_stray_d%0d", e.digit), 32'(bad), 32'd0);
    check($sformatf("an_on_cnt_d%0d", e.digit), 32'(on), 32'(e.on_cnt));
    check($sformatf("an_first_d%0d", e.digit), 32'(first), (e.on_cnt > 0) ? 32'd3 : 32'hFFFF_FFFF);
    check($sformatf("seg_d%0d", e.digit), 32'(s), 32'(e.seg));
    check($sformatf("dp_d%0d", e.digit), 32'(p), 32'(e.dp));
    check($sformatf("frame_done_d%0d", e.digit), 32'(fd), 32'(e.fd));
  endtask

  task automatic run_frame(input int ld_slot, input int ld_j, input logic [15:0] lv,
                           input logic [3:0] ldp, input logic [3:0] lbl);
    for (int sl = 0; sl < 4; sl++) run_slot((sl == ld_slot) ? ld_j : 0, lv, ldp, lbl);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0; brightness = 4'd15;
    repeat (3) @(negedge clock);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_fd", 32'(frame_done), 32'h0);
    reset = 1'b0;

    // Leave a pending load outstanding, then reset mid-slot
    repeat (20) @(negedge clock);
    load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
    @(negedge clock);
    load = 1'b0; dp_in = 4'h0;
    repeat (19) @(negedge clock);
    check("pre_reset_an", 32'(an), 32'hB);
    #2 reset = 1'b1;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp", 32'(dp), 32'h1);
    check("midrst_fd", 32'(frame_done), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Pending load discarded by reset: two frames of zeros
    push_frame(16'h0000, 4'h0, 4'h0, 30); run_frame(-1, 0, 16'h0, 4'h0, 4'h0);
    push_frame(16'h0000, 4'h0, 4'h0, 30); run_frame(0, 5, 16'h12AF, 4'h0, 4'h0);
    push_frame(16'h12AF, 4'h0, 4'h0, 30); run_frame(-1, 0, 16'h0, 4'h0, 4'h0);

    brightness = 4'd4;
    push_frame(16'h12AF, 4'h0, 4'h0, 8);  run_frame(-1, 0, 16'h0, 4'h0, 4'h0);
    brightness = 4'd0;
    push_frame(16'h12AF, 4'h0, 4'h0, 0);  run_frame(-1, 0, 16'h0, 4'h0, 4'h0);
    brightness = 4'd15;

    // Tear-free: mid-frame load waits for the frame boundary
    push_frame(16'h12AF, 4'h0, 4'h0, 30); run_frame(0, 5, 16'h1111, 4'h0, 4'h0);
    push_frame(16'h1111, 4'h0, 4'h0, 30); run_frame(1, 10, 16'h2222, 4'h0, 4'h0);
    // Load exactly in the wrap cycle
    push_frame(16'h2222, 4'h0, 4'h0, 30); run_frame(3, 31, 16'h3456, 4'b0100, 4'b0001);
    // Blank/dp frame, with two loads where the last one wins
    push_frame(16'h3456, 4'b0100, 4'b0001, 30);
    run_slot(5, 16'h7777, 4'h0, 4'h0);
    run_slot(0, 16'h0, 4'h0, 4'h0);
    run_slot(5, 16'h89AB, 4'h0, 4'h0);
    run_slot(0, 16'h0, 4'h0, 4'h0);

    push_frame(16'h89AB, 4'h0, 4'h0, 30); run_frame(0, 5, 16'h00A0, 4'h0, 4'h0);
    push_frame(16'h00A0, 4'h0, 4'h0, 30); run_frame(0, 5, 16'h0000, 4'h0, 4'h0);
    push_frame(16'h0000, 4'h0, 4'h0, 30); run_frame(-1, 0, 16'h0, 4'h0, 4'h0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "bench did not complete");
  end

endmodule
